// File: rtl/pole_mac_scheduler.sv
// Time-multiplexed 7-tap pole section: one shared signed multiplier is sequenced
// over the delay line per accepted sample, with a runtime-writable coefficient bank.
module pole_mac_scheduler #(
    parameter int NTAP = 7,
    parameter int DW   = 12,
    parameter int AW   = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] Yin,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [AW-1:0] Yout,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 coe_we,
    input  logic [2:0]           coe_addr,
    input  logic signed [DW-1:0] coe_wdata,
    output logic                 coe_err
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic [2:0] LAST = 3'(NTAP - 1);
    localparam logic signed [DW-1:0] COE_RST [NTAP] = '{
        12'sd272, 12'sd609, 12'sd250, 12'sd189, 12'sd49, 12'sd13, 12'sd1
    };

    state_t                 state, state_nxt;
    logic signed [DW-1:0]   dly [NTAP];
    logic signed [DW-1:0]   coe [NTAP];
    logic signed [AW-1:0]   acc;
    logic [2:0]             tap;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;

    always_comb begin
        prod     = coe[tap] * dly[tap];
        prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = MAC;
            MAC:     if (tap == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NTAP; k++) begin
                dly[k] <= '0;
                coe[k] <= COE_RST[k];
            end
            acc       <= '0;
            tap       <= '0;
            Yout      <= '0;
            out_valid <= 1'b0;
            coe_err   <= 1'b0;
        end else begin
            // Busy-time writes are flagged whatever the address; idle writes to 7 are silently ignored.
            coe_err <= coe_we && (state != IDLE);
            if (state == IDLE && coe_we && coe_addr <= LAST)
                coe[coe_addr] <= coe_wdata;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = NTAP - 1; k > 0; k--)
                            dly[k] <= dly[k-1];
                        dly[0] <= Yin;
                        acc    <= '0;
                        tap    <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    tap <= tap + 3'd1;
                    if (tap == LAST) begin
                        Yout      <= acc + prod_ext;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pole_mac_scheduler.sv
// Directed self-checking bench for pole_mac_scheduler: impulse, step, coefficient
// writes, backpressure and mid-computation reset.
module tb_pole_mac_scheduler;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] Yin = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [25:0] Yout;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               coe_we = 1'b0;
    logic [2:0]         coe_addr = '0;
    logic signed [11:0] coe_wdata = '0;
    logic               coe_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pole_mac_scheduler #(.NTAP(7), .DW(12), .AW(26)) dut (
        .clk(clk), .rst_n(rst_n), .Yin(Yin), .in_valid(in_valid), .in_ready(in_ready),
        .Yout(Yout), .out_valid(out_valid), .out_ready(out_ready),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_wdata(coe_wdata), .coe_err(coe_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full transaction: wait for ready, accept, count cycles to out_valid, drain.
    task automatic send(input logic signed [11:0] s, output logic signed [25:0] y, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        Yin = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        coe_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        y = Yout;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Yout !== 26'sd0 || coe_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b Yout=%0d coe_err=%b, required 1 0 0 0",
                     in_ready, out_valid, Yout, coe_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_impulse();
        logic signed [11:0] ex [8];
        logic signed [25:0] y;
        int lat;
        ex = '{12'sd272, 12'sd609, 12'sd250, 12'sd189, 12'sd49, 12'sd13, 12'sd1, 12'sd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 12'sd1 : 12'sd0, y, lat);
            checks++;
            if (y !== 26'(ex[i])) begin
                fails++;
                $display("FAIL impulse_y[%0d]: got %0d, required %0d", i, y, ex[i]);
            end
            checks++;
            if (lat != 7) begin
                fails++;
                $display("FAIL impulse_latency[%0d]: got %0d, required 7", i, lat);
            end
        end
    endtask

    task automatic test_neg_step();
        logic signed [25:0] y;
        logic signed [25:0] ex;
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(-12'sd2048, y, lat);
            if (i == 0) begin
                ex = -26'sd557056;
                checks++;
                if (y !== ex) begin
                    fails++;
                    $display("FAIL neg_step_first: got %0d, required %0d", y, ex);
                end
            end
        end
        ex = -26'sd2832384;
        checks++;
        if (y !== ex) begin
            fails++;
            $display("FAIL neg_step_full: got %0d, required %0d", y, ex);
        end
    endtask

    task automatic test_coe_load();
        logic signed [25:0] y;
        logic signed [25:0] ex;
        int lat;
        do_reset();
        coe_we = 1'b1; coe_addr = 3'd0; coe_wdata = -12'sd2048;
        send(12'sd2047, y, lat);
        ex = -26'sd4192256;
        checks++;
        if (y !== ex) begin
            fails++;
            $display("FAIL coe_load_same_edge: got %0d, required %0d", y, ex);
        end
        coe_we = 1'b1; coe_addr = 3'd7; coe_wdata = 12'sd5;
        tick();
        coe_we = 1'b0;
        tick();
        checks++;
        if (coe_err !== 1'b0) begin
            fails++;
            $display("FAIL coe_addr7_err: got %b, required 0", coe_err);
        end
        send(12'sd0, y, lat);
        ex = 26'sd1246623;
        checks++;
        if (y !== ex) begin
            fails++;
            $display("FAIL coe_addr7_nochange: got %0d, required %0d", y, ex);
        end
    endtask

    task automatic test_backpressure();
        logic signed [25:0] y;
        logic signed [25:0] ex;
        int w;
        do_reset();
        Yin = 12'sd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin tick(); w++; end
        Yin = 12'sd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Yout !== 26'sd816 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: Yout=%0d out_valid=%b in_ready=%b, required 816 1 0",
                         i, Yout, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_pending_accept: in_ready=%b, required 0", in_ready);
        end
        w = 0;
        while (!out_valid && w < 20) begin tick(); w++; end
        y = Yout;
        ex = 26'sd3731;
        checks++;
        if (y !== ex || w != 7) begin
            fails++;
            $display("FAIL backpressure_result: Yout=%0d after %0d cycles, required %0d after 7", y, w, ex);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_busy_write();
        logic signed [25:0] y;
        int lat;
        int w;
        do_reset();
        Yin = 12'sd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        coe_we = 1'b1; coe_addr = 3'd2; coe_wdata = 12'sd100;
        tick();
        coe_we = 1'b0;
        checks++;
        if (coe_err !== 1'b1) begin
            fails++;
            $display("FAIL busy_write_err_pulse: got %b, required 1", coe_err);
        end
        tick();
        checks++;
        if (coe_err !== 1'b0) begin
            fails++;
            $display("FAIL busy_write_err_clear: got %b, required 0", coe_err);
        end
        w = 0;
        while (!out_valid && w < 20) begin tick(); w++; end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(12'sd0, y, lat);
        send(12'sd0, y, lat);
        checks++;
        if (y !== 26'sd250) begin
            fails++;
            $display("FAIL busy_write_dropped: got %0d, required 250", y);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [25:0] y;
        int lat;
        int seen;
        do_reset();
        coe_we = 1'b1; coe_addr = 3'd0; coe_wdata = 12'sd3;
        tick();
        coe_we = 1'b0;
        Yin = 12'sd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_mac_reset_ready: got %b, required 1", in_ready);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_mac_reset_quiet: out_valid cycles=%0d in_ready=%b, required 0 1", seen, in_ready);
        end
        send(12'sd1, y, lat);
        checks++;
        if (y !== 26'sd272) begin
            fails++;
            $display("FAIL mid_mac_reset_defaults: got %0d, required 272", y);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_neg_step();
        test_coe_load();
        test_backpressure();
        test_busy_write();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
